// File: rtl/sm4_request_arbiter_if.sv
// Handshake bundle between the SM4 request arbiter, its requesters and the shared core.
// master = arbiter side, slave = requesters/core/parent side.
interface sm4_request_arbiter_if #(
  parameter int unsigned num_req_p    = 4,
  parameter int unsigned group_size_p = 128
);
  localparam int unsigned owner_w_lp = $clog2(num_req_p);

  logic [num_req_p-1:0]              req_v_i;
  logic [num_req_p-1:0]              req_ready_o;
  logic [num_req_p*group_size_p-1:0] req_content_i;
  logic [num_req_p*group_size_p-1:0] req_key_i;
  logic [num_req_p-1:0]              req_decode_i;

  logic [num_req_p-1:0]              resp_v_o;
  logic [group_size_p-1:0]           resp_crypt_o;
  logic                              resp_err_o;
  logic [num_req_p-1:0]              resp_yumi_i;

  logic                              eng_v_o;
  logic                              eng_ready_i;
  logic [group_size_p-1:0]           eng_content_o;
  logic [group_size_p-1:0]           eng_key_o;
  logic                              eng_decode_o;
  logic                              eng_v_i;
  logic [group_size_p-1:0]           eng_crypt_i;
  logic                              eng_yumi_o;

  logic                              busy_o;
  logic [owner_w_lp-1:0]             owner_o;

  modport master (
    input  req_v_i, req_content_i, req_key_i, req_decode_i, resp_yumi_i,
    input  eng_ready_i, eng_v_i, eng_crypt_i,
    output req_ready_o, resp_v_o, resp_crypt_o, resp_err_o,
    output eng_v_o, eng_content_o, eng_key_o, eng_decode_o, eng_yumi_o,
    output busy_o, owner_o
  );

  modport slave (
    output req_v_i, req_content_i, req_key_i, req_decode_i, resp_yumi_i,
    output eng_ready_i, eng_v_i, eng_crypt_i,
    input  req_ready_o, resp_v_o, resp_crypt_o, resp_err_o,
    input  eng_v_o, eng_content_o, eng_key_o, eng_decode_o, eng_yumi_o,
    input  busy_o, owner_o
  );
endinterface

// File: rtl/sm4_request_arbiter.sv
// Round-robin arbiter sharing one SM4 core between num_req_p requesters,
// one operation in flight, with a watchdog on the core's result.
module sm4_request_arbiter #(
  parameter int unsigned num_req_p    = 4,
  parameter int unsigned group_size_p = 128,
  parameter int unsigned timeout_p    = 96
) (
  input logic                 clk_i,
  input logic                 reset_n_i,
  sm4_request_arbiter_if.master bus
);
  localparam int unsigned ow_lp = $clog2(num_req_p);
  localparam int unsigned tw_lp = $clog2(timeout_p + 1);
  localparam logic [ow_lp:0]   n_lp     = (ow_lp + 1)'(num_req_p);
  localparam logic [ow_lp-1:0] last_lp  = ow_lp'(num_req_p - 1);
  localparam logic [tw_lp-1:0] tlast_lp = tw_lp'(timeout_p - 1);

  typedef enum logic [1:0] {eIdle, eIssue, eWait, eReturn} state_e;

  state_e                  state_q,   state_d;
  logic [ow_lp-1:0]        ptr_q,     ptr_d;
  logic [ow_lp-1:0]        owner_q,   owner_d;
  logic [group_size_p-1:0] content_q, content_d;
  logic [group_size_p-1:0] key_q,     key_d;
  logic                    decode_q,  decode_d;
  logic [group_size_p-1:0] result_q,  result_d;
  logic                    err_q,     err_d;
  logic [tw_lp-1:0]        timer_q,   timer_d;

  logic                    found;
  logic [ow_lp-1:0]        winner;
  logic [ow_lp:0]          idx;

  // Search upward from the pointer with wrap; the first valid requester wins.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    idx    = '0;
    for (int unsigned i = 0; i < num_req_p; i++) begin
      idx = {1'b0, ptr_q} + (ow_lp + 1)'(i);
      if (idx >= n_lp) idx = idx - n_lp;
      if (!found && bus.req_v_i[idx[ow_lp-1:0]]) begin
        found  = 1'b1;
        winner = idx[ow_lp-1:0];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    owner_d   = owner_q;
    content_d = content_q;
    key_d     = key_q;
    decode_d  = decode_q;
    result_d  = result_q;
    err_d     = err_q;
    timer_d   = timer_q;
    unique case (state_q)
      eIdle: begin
        if (found) begin
          content_d = bus.req_content_i[winner*group_size_p +: group_size_p];
          key_d     = bus.req_key_i[winner*group_size_p +: group_size_p];
          decode_d  = bus.req_decode_i[winner];
          owner_d   = winner;
          ptr_d     = (winner == last_lp) ? '0 : winner + 1'b1;
          state_d   = eIssue;
        end
      end
      eIssue: begin
        if (bus.eng_ready_i) begin
          timer_d = '0;
          state_d = eWait;
        end
      end
      eWait: begin
        // A result arriving on the final timer cycle takes precedence over the abort.
        if (bus.eng_v_i) begin
          result_d = bus.eng_crypt_i;
          err_d    = 1'b0;
          state_d  = eReturn;
        end else if (timer_q == tlast_lp) begin
          result_d = '0;
          err_d    = 1'b1;
          state_d  = eReturn;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      eReturn: begin
        if (bus.resp_yumi_i[owner_q]) state_d = eIdle;
      end
      default: state_d = eIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q   <= eIdle;
      ptr_q     <= '0;
      owner_q   <= '0;
      content_q <= '0;
      key_q     <= '0;
      decode_q  <= 1'b0;
      result_q  <= '0;
      err_q     <= 1'b0;
      timer_q   <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      owner_q   <= owner_d;
      content_q <= content_d;
      key_q     <= key_d;
      decode_q  <= decode_d;
      result_q  <= result_d;
      err_q     <= err_d;
      timer_q   <= timer_d;
    end
  end

  // Ready is gated by reset so every output reads 0 while reset is held.
  always_comb begin
    bus.req_ready_o = '0;
    bus.resp_v_o    = '0;
    if (state_q == eIdle && found && reset_n_i) bus.req_ready_o[winner] = 1'b1;
    if (state_q == eReturn) bus.resp_v_o[owner_q] = 1'b1;
  end

  assign bus.resp_crypt_o  = (state_q == eReturn) ? result_q : '0;
  assign bus.resp_err_o    = (state_q == eReturn) && err_q;
  assign bus.eng_v_o       = (state_q == eIssue);
  assign bus.eng_content_o = content_q;
  assign bus.eng_key_o     = key_q;
  assign bus.eng_decode_o  = decode_q;
  assign bus.eng_yumi_o    = (state_q == eWait) && bus.eng_v_i;
  assign bus.busy_o        = (state_q != eIdle);
  assign bus.owner_o       = owner_q;
endmodule

// File: tb/tb_sm4_request_arbiter.sv
// Directed self-checking bench for sm4_request_arbiter with a simple core model.
module tb_sm4_request_arbiter;
  localparam int TMO = 96;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  logic [127:0] cont [4];
  logic [127:0] keyv [4];
  logic [3:0]   dec;

  sm4_request_arbiter_if #(.num_req_p(4), .group_size_p(128)) bus ();

  sm4_request_arbiter #(.num_req_p(4), .group_size_p(128), .timeout_p(TMO)) dut (
    .clk_i     (clk),
    .reset_n_i (rst_n),
    .bus       (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [127:0] core_f(input logic [127:0] c, input logic [127:0] k, input logic d);
    return c ^ {k[63:0], k[127:64]} ^ {127'b0, d};
  endfunction

  task automatic load_operands();
    for (int k = 0; k < 4; k++) begin
      bus.req_content_i[k*128 +: 128] = cont[k];
      bus.req_key_i[k*128 +: 128]     = keyv[k];
    end
    bus.req_decode_i = dec;
  endtask

  // Drives one full operation and reports what was observed; lat<0 means the core never answers.
  task automatic do_op(input logic [3:0] reqv, input int stall, input int lat,
                       input logic [3:0] wrong, input bit use_fixed, input logic [127:0] fixed,
                       output int grant, output bit onehot_ok, output bit stable_ok, output int wcnt,
                       output logic [127:0] crypt, output logic err, output logic [3:0] respv,
                       output bit wrong_ok, output bit tmo);
    int n;
    logic [127:0] c0, k0;
    logic d0;
    grant = -1; onehot_ok = 1; stable_ok = 1; wcnt = 0; crypt = '0; err = 0;
    respv = '0; wrong_ok = 1; tmo = 0;
    @(negedge clk); bus.req_v_i = reqv; #1;
    n = 0;
    while (bus.req_ready_o == '0 && n < 20) begin @(negedge clk); #1; n++; end
    if (bus.req_ready_o == '0) begin tmo = 1; bus.req_v_i = '0; return; end
    if (!$onehot(bus.req_ready_o)) onehot_ok = 0;
    for (int i = 0; i < 4; i++) if (bus.req_ready_o[i]) grant = i;
    @(negedge clk); #1;
    c0 = bus.eng_content_o; k0 = bus.eng_key_o; d0 = bus.eng_decode_o;
    for (int s = 0; s <= stall; s++) begin
      if (bus.eng_v_o !== 1'b1 || bus.eng_content_o !== c0 || bus.eng_key_o !== k0 ||
          bus.eng_decode_o !== d0) stable_ok = 0;
      if (bus.req_ready_o !== '0) onehot_ok = 0;
      if (s == stall) bus.eng_ready_i = 1'b1;
      @(negedge clk); bus.eng_ready_i = 1'b0; #1;
    end
    for (int k = 0; k < 200; k++) begin
      if (k == lat) begin
        bus.eng_v_i     = 1'b1;
        bus.eng_crypt_i = use_fixed ? fixed : core_f(c0, k0, d0);
      end
      if (bus.req_ready_o !== '0) onehot_ok = 0;
      @(negedge clk); bus.eng_v_i = 1'b0; bus.eng_crypt_i = '0; #1;
      if (bus.resp_v_o != '0) begin wcnt = k + 1; break; end
    end
    if (bus.resp_v_o == '0) begin tmo = 1; bus.req_v_i = '0; return; end
    respv = bus.resp_v_o; crypt = bus.resp_crypt_o; err = bus.resp_err_o;
    if (wrong != '0) begin
      bus.resp_yumi_i = wrong; @(negedge clk); bus.resp_yumi_i = '0; #1;
      if (bus.resp_v_o !== respv || bus.busy_o !== 1'b1) wrong_ok = 0;
    end
    bus.resp_yumi_i = respv; @(negedge clk); bus.resp_yumi_i = '0; bus.req_v_i = '0; #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.req_v_i = 4'hf;
    #3;
    checks++; if (bus.req_ready_o !== 4'b0) begin errors++; $display("FAIL reset_ready got %b exp 0000", bus.req_ready_o); end
    checks++; if (bus.busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", bus.busy_o); end
    checks++; if (bus.eng_v_o !== 1'b0 || bus.resp_v_o !== 4'b0 || bus.resp_err_o !== 1'b0) begin errors++; $display("FAIL reset_valids got eng_v=%b resp_v=%b err=%b exp all 0", bus.eng_v_o, bus.resp_v_o, bus.resp_err_o); end
    checks++; if (bus.eng_content_o !== '0 || bus.resp_crypt_o !== '0 || bus.owner_o !== 2'd0) begin errors++; $display("FAIL reset_data got content=%h crypt=%h owner=%0d exp 0", bus.eng_content_o, bus.resp_crypt_o, bus.owner_o); end
    bus.req_v_i = '0;
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_round_robin();
    int g, w; bit oh, st, wo, to; logic [127:0] c; logic e; logic [3:0] rv;
    for (int j = 0; j < 8; j++) begin
      do_op(4'hf, 0, 3 + j, 4'b0, 0, '0, g, oh, st, w, c, e, rv, wo, to);
      checks++; if (to) begin errors++; $display("FAIL rr_timeout op %0d got stall exp progress", j); end
      checks++; if (g !== j % 4) begin errors++; $display("FAIL rr_grant op %0d got %0d exp %0d", j, g, j % 4); end
      checks++; if (!oh) begin errors++; $display("FAIL rr_onehot op %0d got non-one-hot ready exp one-hot or zero", j); end
      checks++; if (rv !== 4'(1 << (j % 4)) || e !== 1'b0) begin errors++; $display("FAIL rr_resp op %0d got v=%b err=%b exp v=%b err=0", j, rv, e, 4'(1 << (j % 4))); end
      checks++; if (c !== core_f(cont[j % 4], keyv[j % 4], dec[j % 4])) begin errors++; $display("FAIL rr_crypt op %0d got %h exp %h", j, c, core_f(cont[j % 4], keyv[j % 4], dec[j % 4])); end
      checks++; if (w !== 4 + j) begin errors++; $display("FAIL rr_latency op %0d got %0d exp %0d", j, w, 4 + j); end
      checks++; if (bus.owner_o !== 2'(j % 4)) begin errors++; $display("FAIL rr_owner op %0d got %0d exp %0d", j, bus.owner_o, j % 4); end
    end
  endtask

  task automatic test_single();
    int g, w; bit oh, st, wo, to; logic [127:0] c; logic e; logic [3:0] rv;
    cont[2] = 128'h0123456789abcdeffedcba9876543210;
    keyv[2] = 128'h0123456789abcdeffedcba9876543210;
    dec[2]  = 1'b0;
    load_operands();
    do_op(4'b0100, 0, 66, 4'b0, 1, 128'h681edf34d206965e86b3e94f536e4246, g, oh, st, w, c, e, rv, wo, to);
    checks++; if (to || rv !== 4'b0100) begin errors++; $display("FAIL single_resp_v got %b (stuck=%0d) exp 0100", rv, to); end
    checks++; if (c !== 128'h681edf34d206965e86b3e94f536e4246) begin errors++; $display("FAIL single_crypt got %h exp 681edf34d206965e86b3e94f536e4246", c); end
    checks++; if (e !== 1'b0) begin errors++; $display("FAIL single_err got %b exp 0", e); end
    checks++; if (w !== 67) begin errors++; $display("FAIL single_latency got %0d exp 67", w); end
    checks++; if (bus.busy_o !== 1'b0) begin errors++; $display("FAIL single_busy_after_yumi got %b exp 0", bus.busy_o); end
  endtask

  task automatic test_ready_stall();
    int g, w; bit oh, st, wo, to; logic [127:0] c; logic e; logic [3:0] rv;
    do_op(4'b0001, 5, 3, 4'b0, 0, '0, g, oh, st, w, c, e, rv, wo, to);
    checks++; if (to || g !== 0) begin errors++; $display("FAIL stall_grant got %0d (stuck=%0d) exp 0", g, to); end
    checks++; if (!st) begin errors++; $display("FAIL stall_operands got unstable or dropped eng_v_o exp stable"); end
    checks++; if (e !== 1'b0 || rv !== 4'b0001) begin errors++; $display("FAIL stall_resp got v=%b err=%b exp v=0001 err=0", rv, e); end
    checks++; if (c !== core_f(cont[0], keyv[0], dec[0])) begin errors++; $display("FAIL stall_crypt got %h exp %h", c, core_f(cont[0], keyv[0], dec[0])); end
    checks++; if (w !== 4) begin errors++; $display("FAIL stall_latency got %0d exp 4", w); end
  endtask

  task automatic test_timeout();
    int g, w; bit oh, st, wo, to; logic [127:0] c; logic e; logic [3:0] rv;
    do_op(4'b1000, 0, -1, 4'b0, 0, '0, g, oh, st, w, c, e, rv, wo, to);
    checks++; if (to || rv !== 4'b1000) begin errors++; $display("FAIL timeout_resp_v got %b (stuck=%0d) exp 1000", rv, to); end
    checks++; if (e !== 1'b1 || c !== '0) begin errors++; $display("FAIL timeout_err got err=%b crypt=%h exp err=1 crypt=0", e, c); end
    checks++; if (w !== TMO) begin errors++; $display("FAIL timeout_cycles got %0d exp %0d", w, TMO); end
    do_op(4'b0010, 0, TMO - 1, 4'b0, 0, '0, g, oh, st, w, c, e, rv, wo, to);
    checks++; if (to || rv !== 4'b0010) begin errors++; $display("FAIL lastcycle_resp_v got %b (stuck=%0d) exp 0010", rv, to); end
    checks++; if (e !== 1'b0) begin errors++; $display("FAIL lastcycle_err got %b exp 0", e); end
    checks++; if (c !== core_f(cont[1], keyv[1], dec[1]) || w !== TMO) begin errors++; $display("FAIL lastcycle_crypt got %h after %0d exp %h after %0d", c, w, core_f(cont[1], keyv[1], dec[1]), TMO); end
  endtask

  task automatic test_wrong_yumi();
    int g, w; bit oh, st, wo, to; logic [127:0] c; logic e; logic [3:0] rv;
    do_op(4'b0010, 0, 2, 4'b1000, 0, '0, g, oh, st, w, c, e, rv, wo, to);
    checks++; if (to || rv !== 4'b0010) begin errors++; $display("FAIL wrongyumi_resp_v got %b (stuck=%0d) exp 0010", rv, to); end
    checks++; if (!wo) begin errors++; $display("FAIL wrongyumi_hold got state change exp hold in return"); end
    checks++; if (bus.busy_o !== 1'b0) begin errors++; $display("FAIL wrongyumi_release got busy=%b exp 0", bus.busy_o); end
  endtask

  task automatic test_async_reset();
    @(negedge clk); bus.req_v_i = 4'b0010; #1;
    checks++; if (bus.req_ready_o !== 4'b0010) begin errors++; $display("FAIL areset_pre_grant got %b exp 0010", bus.req_ready_o); end
    @(negedge clk); bus.req_v_i = '0; bus.eng_ready_i = 1'b1;
    @(negedge clk); bus.eng_ready_i = 1'b0;
    @(negedge clk); #1; bus.eng_v_i = 1'b1; #1;
    checks++; if (bus.eng_yumi_o !== 1'b1 || bus.busy_o !== 1'b1) begin errors++; $display("FAIL areset_in_wait got yumi=%b busy=%b exp 1 1", bus.eng_yumi_o, bus.busy_o); end
    rst_n = 1'b0; #1;
    checks++; if (bus.busy_o !== 1'b0 || bus.eng_yumi_o !== 1'b0 || bus.eng_v_o !== 1'b0) begin errors++; $display("FAIL areset_ctrl got busy=%b yumi=%b eng_v=%b exp 0", bus.busy_o, bus.eng_yumi_o, bus.eng_v_o); end
    checks++; if (bus.owner_o !== 2'd0 || bus.eng_content_o !== '0 || bus.eng_key_o !== '0 || bus.resp_v_o !== 4'b0) begin errors++; $display("FAIL areset_data got owner=%0d content=%h key=%h resp_v=%b exp 0", bus.owner_o, bus.eng_content_o, bus.eng_key_o, bus.resp_v_o); end
    bus.eng_v_i = 1'b0;
    @(negedge clk); rst_n = 1'b1; bus.req_v_i = 4'b1001; #1;
    checks++; if (bus.req_ready_o !== 4'b0001) begin errors++; $display("FAIL areset_ptr got %b exp 0001", bus.req_ready_o); end
    @(negedge clk); bus.req_v_i = '0; #1;
    checks++; if (bus.owner_o !== 2'd0 || bus.eng_v_o !== 1'b1 || bus.eng_content_o !== cont[0]) begin errors++; $display("FAIL areset_accept got owner=%0d eng_v=%b content=%h exp 0 1 %h", bus.owner_o, bus.eng_v_o, bus.eng_content_o, cont[0]); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    for (int k = 0; k < 4; k++) begin
      cont[k] = {4{32'hc0de0000 + 32'(k)}};
      keyv[k] = {4{32'hbeef0000 + 32'(3 * k + 1)}};
    end
    dec = 4'b1010;
    bus.req_v_i = '0; bus.resp_yumi_i = '0;
    bus.eng_ready_i = 1'b0; bus.eng_v_i = 1'b0; bus.eng_crypt_i = '0;
    load_operands();
    test_reset();
    test_round_robin();
    test_single();
    test_ready_stall();
    test_timeout();
    test_wrong_yumi();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
